// File: rtl/ring_cal_ctrl.sv
// SAR calibration controller for the inverter-ring delay line: trials delay codes
// MSB-first, scoring each against a ring edge count taken over a fixed clk window.
module ring_cal_ctrl #(
    parameter int CODE_W     = 6,
    parameter int SETTLE_CYC = 4,
    parameter int WIN_CYC    = 64,
    parameter int DELAY_BASE = 20000,
    parameter int DELAY_STEP = 500,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  target_cnt,
    input  logic              cfg_load,
    input  logic [CODE_W-1:0] cfg_code,
    input  logic [CNT_W-1:0]  ring_cnt,
    output logic              cnt_clr,
    output logic              ring_en,
    output logic [31:0]       delay_fs,
    output logic [CODE_W-1:0] code,
    output logic              busy,
    output logic              done,
    output logic              lock
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_EVAL    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int PH_W  = $clog2((WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC) + 1;
    localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    localparam logic [PH_W-1:0]  SET_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0]  WIN_LAST = PH_W'(WIN_CYC - 1);
    localparam logic [BIT_W-1:0] MSB_IDX  = BIT_W'(CODE_W - 1);
    localparam logic [31:0]      BASE_FS  = 32'(DELAY_BASE);
    localparam logic [31:0]      STEP_FS  = 32'(DELAY_STEP);

    logic [2:0]        state, state_nxt;
    logic [PH_W-1:0]   ph, ph_nxt;
    logic [BIT_W-1:0]  bidx, bidx_nxt, bidx_m1;
    logic [CNT_W-1:0]  tgt, tgt_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic              ring_en_nxt, lock_nxt;

    assign bidx_m1 = bidx - BIT_W'(1);

    always_comb begin
        state_nxt   = state;
        ph_nxt      = ph;
        bidx_nxt    = bidx;
        tgt_nxt     = tgt;
        code_nxt    = code;
        ring_en_nxt = ring_en;
        lock_nxt    = lock;
        case (state)
            S_IDLE: begin
                if (start) begin
                    tgt_nxt               = target_cnt;
                    bidx_nxt              = MSB_IDX;
                    code_nxt              = '0;
                    code_nxt[CODE_W-1]    = 1'b1;
                    ring_en_nxt           = 1'b1;
                    lock_nxt              = 1'b0;
                    ph_nxt                = '0;
                    state_nxt             = S_SETTLE;
                end else if (cfg_load) begin
                    code_nxt    = cfg_code;
                    ring_en_nxt = 1'b1;
                    lock_nxt    = 1'b1;
                end
            end
            S_SETTLE: begin
                if (ph == SET_LAST) begin
                    ph_nxt    = '0;
                    state_nxt = S_MEASURE;
                end else begin
                    ph_nxt = ph + PH_W'(1);
                end
            end
            S_MEASURE: begin
                if (ph == WIN_LAST) begin
                    ph_nxt    = '0;
                    state_nxt = S_EVAL;
                end else begin
                    ph_nxt = ph + PH_W'(1);
                end
            end
            S_EVAL: begin
                // Ring faster than target means delay too small: keep the trial bit.
                if (!(ring_cnt > tgt)) code_nxt[bidx] = 1'b0;
                if (bidx != '0) begin
                    bidx_nxt          = bidx_m1;
                    code_nxt[bidx_m1] = 1'b1;
                    state_nxt         = S_SETTLE;
                end else begin
                    lock_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ph       <= '0;
            bidx     <= '0;
            tgt      <= '0;
            code     <= '0;
            delay_fs <= BASE_FS;
            ring_en  <= 1'b0;
            lock     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ph       <= ph_nxt;
            bidx     <= bidx_nxt;
            tgt      <= tgt_nxt;
            code     <= code_nxt;
            delay_fs <= BASE_FS + 32'(code_nxt) * STEP_FS;
            ring_en  <= ring_en_nxt;
            lock     <= lock_nxt;
        end
    end

    assign cnt_clr = (state != S_MEASURE);
    assign busy    = (state == S_SETTLE) || (state == S_MEASURE) || (state == S_EVAL);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_ring_cal_ctrl.sv
// Directed bench for ring_cal_ctrl: linear ring model cnt = 1000 - 10*code, target 700.
module tb_ring_cal_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, cfg_load;
    logic [15:0] target_cnt, ring_cnt;
    logic [5:0]  cfg_code, code;
    logic        cnt_clr, ring_en, busy, done, lock;
    logic [31:0] delay_fs;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Faster ring (larger count) at smaller codes.
    assign ring_cnt = 16'(1000 - 10 * int'(code));

    ring_cal_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .target_cnt(target_cnt),
        .cfg_load(cfg_load), .cfg_code(cfg_code), .ring_cnt(ring_cnt),
        .cnt_clr(cnt_clr), .ring_en(ring_en), .delay_fs(delay_fs), .code(code),
        .busy(busy), .done(done), .lock(lock)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_cmp++; if (code !== 6'd0) begin n_bad++; $display("FAIL reset_code got %0d exp 0", code); end
        n_cmp++; if (delay_fs !== 32'd20000) begin n_bad++; $display("FAIL reset_delay got %0d exp 20000", delay_fs); end
        n_cmp++; if (ring_en !== 1'b0) begin n_bad++; $display("FAIL reset_ring_en got %b exp 0", ring_en); end
        n_cmp++; if (cnt_clr !== 1'b1) begin n_bad++; $display("FAIL reset_cnt_clr got %b exp 1", cnt_clr); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
        n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL reset_lock got %b exp 0", lock); end
    endtask

    task automatic test_manual();
        cfg_code = 6'd10;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        n_cmp++; if (code !== 6'd10) begin n_bad++; $display("FAIL manual_code got %0d exp 10", code); end
        n_cmp++; if (delay_fs !== 32'd25000) begin n_bad++; $display("FAIL manual_delay got %0d exp 25000", delay_fs); end
        n_cmp++; if (ring_en !== 1'b1 || lock !== 1'b1) begin n_bad++; $display("FAIL manual_en_lock got %b%b exp 11", ring_en, lock); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL manual_busy got %b exp 0", busy); end
    endtask

    // start and cfg_load together: calibration wins, then rst 100 cycles in aborts it.
    task automatic test_priority_abort();
        int done_seen = 0;
        target_cnt = 16'd700;
        cfg_code   = 6'd5;
        start      = 1'b1;
        cfg_load   = 1'b1;
        tick();
        start    = 1'b0;
        cfg_load = 1'b0;
        n_cmp++; if (code !== 6'd32) begin n_bad++; $display("FAIL prio_code got %0d exp 32", code); end
        n_cmp++; if (delay_fs !== 32'd36000) begin n_bad++; $display("FAIL prio_delay got %0d exp 36000", delay_fs); end
        n_cmp++; if (busy !== 1'b1 || lock !== 1'b0) begin n_bad++; $display("FAIL prio_busy_lock got %b%b exp 10", busy, lock); end
        for (int i = 0; i < 99; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (done === 1'b1) done_seen++;
        n_cmp++; if (code !== 6'd0 || delay_fs !== 32'd20000) begin n_bad++; $display("FAIL abort_code got %0d/%0d exp 0/20000", code, delay_fs); end
        n_cmp++; if (ring_en !== 1'b0 || cnt_clr !== 1'b1) begin n_bad++; $display("FAIL abort_en_clr got %b%b exp 01", ring_en, cnt_clr); end
        n_cmp++; if (busy !== 1'b0 || lock !== 1'b0) begin n_bad++; $display("FAIL abort_busy_lock got %b%b exp 00", busy, lock); end
        n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d pulses exp 0", done_seen); end
    endtask

    // Full SAR run; inject=1 pulses start/cfg_load and moves target_cnt mid-window.
    task automatic run_cal(input bit inject, input string tag);
        logic [5:0] exp_tr [6] = '{6'd32, 6'd16, 6'd24, 6'd28, 6'd30, 6'd29};
        logic [5:0] trial  [6];
        logic [5:0] eq_code = '0;
        int gate_err = 0;
        int done_cnt = 0;
        int done_at  = -1;
        int obs, ph;
        logic exp_clr;
        target_cnt = 16'd700;
        cfg_load   = 1'b0;
        start      = 1'b1;
        for (int cyc = 1; cyc <= 415; cyc++) begin
            tick();
            obs = cyc - 1;
            ph  = obs % 69;
            exp_clr = !(cyc <= 414 && ph >= 4 && ph <= 67);
            if (cnt_clr !== exp_clr) gate_err++;
            if (done === 1'b1) begin done_cnt++; done_at = cyc; end
            if (ph == 0 && obs < 414) trial[obs / 69] = code;
            if (obs == 345) eq_code = code;
            start    = inject && (cyc == 10 || cyc == 150);
            cfg_load = start;
            cfg_code = 6'd3;
            if (inject && cyc == 10) target_cnt = 16'd0;
        end
        start    = 1'b0;
        cfg_load = 1'b0;
        for (int t = 0; t < 6; t++) begin
            n_cmp++;
            if (trial[t] !== exp_tr[t]) begin n_bad++; $display("FAIL %s_trial%0d got %0d exp %0d", tag, t, trial[t], exp_tr[t]); end
        end
        n_cmp++; if ((eq_code & 6'b111110) !== 6'd28) begin n_bad++; $display("FAIL %s_equal_clears got %0d exp 28|1", tag, eq_code); end
        n_cmp++; if (gate_err !== 0) begin n_bad++; $display("FAIL %s_window_gating got %0d bad cycles exp 0", tag, gate_err); end
        n_cmp++; if (done_cnt !== 1 || done_at !== 415) begin n_bad++; $display("FAIL %s_done_timing got %0d pulses at %0d exp 1 at 415", tag, done_cnt, done_at); end
        n_cmp++; if (code !== 6'd29 || delay_fs !== 32'd34500) begin n_bad++; $display("FAIL %s_final got %0d/%0d exp 29/34500", tag, code, delay_fs); end
        n_cmp++; if (busy !== 1'b0 || lock !== 1'b1 || ring_en !== 1'b1) begin n_bad++; $display("FAIL %s_done_flags got b%b l%b e%b exp b0 l1 e1", tag, busy, lock, ring_en); end
        tick();
        n_cmp++; if (done !== 1'b0 || code !== 6'd29 || lock !== 1'b1 || cnt_clr !== 1'b1) begin n_bad++; $display("FAIL %s_post_done got d%b c%0d l%b clr%b exp d0 c29 l1 clr1", tag, done, code, lock, cnt_clr); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cfg_load = 1'b0;
        cfg_code = '0; target_cnt = '0;
        test_reset();
        test_manual();
        test_priority_abort();
        run_cal(1'b0, "nominal");
        run_cal(1'b1, "busy_mask");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ring_cal_ctrl.md
Name: ring_cal_ctrl

Overview:
- Calibration controller for the inverter-ring delay line in the TDC/DCO model.
- Drives the common `delay_fs` applied to every ring inverter stage, plus the ring enable.
- Tunes the delay code by successive approximation (SAR): each trial is scored by an external ring-edge count taken over a fixed clk window and compared against a target count.
- Also accepts a manual code load when idle. Non-synthesisable model context; behaviour is still cycle-exact on clk.

Parameters:
- CODE_W, 6, width of the delay code (SAR steps).
- SETTLE_CYC, 4, clk cycles of ring settling per trial; counter held clear.
- WIN_CYC, 64, clk cycles of the count window per trial.
- DELAY_BASE, 20000, delay in fs at code 0.
- DELAY_STEP, 500, fs added per code LSB.
- CNT_W, 16, width of the ring edge count and the target.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- start, in, 1: pulse that begins calibration; sampled only in IDLE.
- target_cnt, in, CNT_W: desired edge count per window; sampled at start.
- cfg_load, in, 1: manual code load; honoured only in IDLE when start=0.
- cfg_code, in, CODE_W: code for cfg_load.
- ring_cnt, in, CNT_W: ring edge count from the external counter.
- cnt_clr, out, 1: clears the external counter.
- ring_en, out, 1: ring oscillator enable.
- delay_fs, out, 32: per-stage inverter delay.
- code, out, CODE_W: current or final delay code.
- busy, out, 1: calibration in progress.
- done, out, 1: one-cycle pulse at calibration end.
- lock, out, 1: a calibrated or manual code is in effect.

Behaviour:
- Reset: state IDLE, code=0, delay_fs=DELAY_BASE, ring_en=0, cnt_clr=1, busy=0, done=0, lock=0. rst mid-calibration aborts immediately to these values; no done pulse.
- delay_fs is registered as DELAY_BASE + code*DELAY_STEP, computed in 32 bits and updated the same edge code changes. Parameter choice must keep the result below 2^32; there is no saturation.
- States: IDLE, SETTLE, MEASURE, EVAL, DONE. A phase counter counts cycles inside SETTLE and MEASURE.
- IDLE:
  - start=1 at edge k: latch target_cnt; bit index b=CODE_W-1; code=1<<b; busy=1; ring_en=1; lock=0; go to SETTLE.
  - Otherwise cfg_load=1: code=cfg_code; ring_en=1; lock=1; stay in IDLE.
  - start has priority over cfg_load.
- SETTLE: cnt_clr=1 for exactly SETTLE_CYC cycles, then MEASURE.
- MEASURE: cnt_clr=0 for exactly WIN_CYC cycles, then EVAL.
- EVAL (1 cycle):
  - Sample ring_cnt; cnt_clr=1.
  - If ring_cnt > latched target (strict; ring too fast), keep bit b, otherwise clear it. Equal counts clear the bit.
  - If b>0: b=b-1, set bit b of code, go to SETTLE.
  - If b=0: go to DONE.
- DONE (1 cycle): done=1, busy=0, lock=1, code held, then IDLE.
- ring_en stays 1 after DONE and after a manual load, until rst.
- cnt_clr=1 whenever state is not MEASURE.
- Trial period T=SETTLE_CYC+WIN_CYC+1 = 69. done is high in cycle k+CODE_W*T+1 = k+415 with defaults.
- start, cfg_load and cfg_code changes while busy are ignored. target_cnt changes while busy have no effect.
- Code arithmetic never wraps: the SAR result lies in [0, 2^CODE_W-1].

Test Plan:
- Reset values: assert rst for 3 cycles → code=0, delay_fs=20000, ring_en=0, cnt_clr=1, busy=0, lock=0.
- Nominal SAR: bench ring model returns ring_cnt=1000-10*code at EVAL; target_cnt=700; pulse start.
  - Trial codes must be 32, 16, 24, 28, 30, 29.
  - Final code=29, delay_fs=34500, done pulse 415 cycles after start, lock=1, busy=0.
- Equality boundary: check in the nominal run that trial 30 (count 700 == target) clears bit 1 → code 28 after that EVAL.
- Manual load: in IDLE, cfg_load=1 with cfg_code=10 → next cycle code=10, delay_fs=25000, ring_en=1, lock=1.
  - Repeat with start and cfg_load both high → calibration starts and cfg_code is ignored.
- Abort: rst asserted 100 cycles after start → next cycle all reset values, no done pulse.
  - A following start runs the full 415-cycle sequence.
- Busy masking: start and cfg_load pulsed during MEASURE → no effect on code, trial sequence or done timing.
- Window gating: check cnt_clr=0 for exactly 64 consecutive cycles per trial, preceded by 4 cycles high.
